// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter, Start/Ack run handshake, relative and
// absolute control transfers, saturating cycle/instruction counters.
// Optional hardware return-address stack enabled by defining FETCH_RAS_EN;
// the default build has no stack storage and StackErr tied low.
module fetch_sequencer #(
  parameter int AW        = 10,
  parameter int OFFW      = 6,
  parameter int CW        = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic            Clk,
  input  logic            ResetN,
  input  logic            Start,
  input  logic [AW-1:0]   StartPC,
  input  logic            Halt,
  input  logic            Stall,
  input  logic            BranchEn,
  input  logic            BranchFlag,
  input  logic [OFFW-1:0] Offset,
  input  logic            Call,
  input  logic            Ret,
  input  logic [AW-1:0]   JumpTarget,
  output logic [AW-1:0]   ProgCtr,
  output logic            Running,
  output logic            Ack,
  output logic            StackErr,
  output logic [CW-1:0]   CycleCt,
  output logic [CW-1:0]   InstrCt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic            running_q, running_d;
  logic            ack_q, ack_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [CW-1:0]   ins_q, ins_d;

  logic [AW-1:0]   pc_inc_s;
  logic [AW-1:0]   offset_ext_s;
  logic [AW-1:0]   ret_target_s;
  logic            clr_s;
  logic            do_push_s;
  logic            do_pop_s;

  // Counters stop at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  assign pc_inc_s     = pc_q + AW'(1);
  assign offset_ext_s = AW'($signed(Offset));

  // Next-state, next-PC and counter update; Start overrides everything.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cyc_d     = cyc_q;
    ins_d     = ins_q;
    clr_s     = 1'b0;
    do_push_s = 1'b0;
    do_pop_s  = 1'b0;
    if (Start) begin
      state_d = ST_RUN;
      pc_d    = StartPC;
      cyc_d   = {CW{1'b0}};
      ins_d   = {CW{1'b0}};
      clr_s   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_RUN: begin
          cyc_d = sat_inc(cyc_q);
          if (Halt) begin
            state_d = ST_DONE;
            ins_d   = sat_inc(ins_q);
          end else if (Stall) begin
            pc_d = pc_q;
          end else begin
            ins_d = sat_inc(ins_q);
            if (Ret) begin
              do_pop_s = 1'b1;
              pc_d     = ret_target_s;
            end else if (Call) begin
              do_push_s = 1'b1;
              pc_d      = JumpTarget;
            end else if (BranchEn && BranchFlag) begin
              pc_d = pc_q + offset_ext_s;
            end else begin
              pc_d = pc_inc_s;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    running_d = (state_d == ST_RUN);
    ack_d     = (state_d == ST_DONE);
  end

  // Sequencer state, PC, handshake outputs and counters.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q   <= ST_IDLE;
      pc_q      <= {AW{1'b0}};
      running_q <= 1'b0;
      ack_q     <= 1'b0;
      cyc_q     <= {CW{1'b0}};
      ins_q     <= {CW{1'b0}};
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      running_q <= running_d;
      ack_q     <= ack_d;
      cyc_q     <= cyc_d;
      ins_q     <= ins_d;
    end
  end

`ifdef FETCH_RAS_EN
  localparam int SPW = $clog2(RAS_DEPTH);

  // Circular return stack: wr_ptr is the next slot, cnt the valid depth.
  logic [AW-1:0]  ras_q [RAS_DEPTH];
  logic [AW-1:0]  ras_d [RAS_DEPTH];
  logic [SPW-1:0] wr_ptr_q, wr_ptr_d;
  logic [SPW:0]   cnt_q, cnt_d;
  logic           err_q, err_d;

  // An empty pop returns address 0.
  assign ret_target_s = (cnt_q == (SPW+1)'(0)) ? {AW{1'b0}} : ras_q[wr_ptr_q - SPW'(1)];

  // Push/pop bookkeeping; a full push overwrites the oldest entry.
  always_comb begin
    ras_d    = ras_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (clr_s) begin
      wr_ptr_d = {SPW{1'b0}};
      cnt_d    = {(SPW+1){1'b0}};
      err_d    = 1'b0;
    end else if (do_pop_s) begin
      if (cnt_q == (SPW+1)'(0)) begin
        err_d = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q - SPW'(1);
        cnt_d    = cnt_q - (SPW+1)'(1);
      end
    end else if (do_push_s) begin
      ras_d[wr_ptr_q] = pc_inc_s;
      wr_ptr_d        = wr_ptr_q + SPW'(1);
      if (cnt_q == (SPW+1)'(RAS_DEPTH)) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + (SPW+1)'(1);
      end
    end else begin
      err_d = err_q;
    end
  end

  // Return-stack storage, pointer and sticky error flag.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= {AW{1'b0}};
      end
      wr_ptr_q <= {SPW{1'b0}};
      cnt_q    <= {(SPW+1){1'b0}};
      err_q    <= 1'b0;
    end else begin
      ras_q    <= ras_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign StackErr = err_q;
`else
  // Without a stack, Ret falls through to the next instruction.
  logic unused_s;
  assign ret_target_s = pc_inc_s;
  assign unused_s     = ^{clr_s, do_push_s, do_pop_s, RAS_DEPTH[0]};
  assign StackErr     = 1'b0;
`endif

  assign ProgCtr = pc_q;
  assign Running = running_q;
  assign Ack     = ack_q;
  assign CycleCt = cyc_q;
  assign InstrCt = ins_q;

endmodule
